// File: rtl/pipe_ctrl_pkg.sv
// Shared control-path types for the pipelined control unit.
// MUL/DIV decode is built only when MULTICYCLE_EN is defined.
package pipe_ctrl_pkg;

    localparam int OPC_W = 4;
    localparam int FNC_W = 4;
    localparam int ALU_W = 3;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'b0000;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'b0001;
    localparam logic [OPC_W-1:0] OP_BGT   = 4'b0100;
    localparam logic [OPC_W-1:0] OP_BLT   = 4'b0101;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'b0110;
    localparam logic [OPC_W-1:0] OP_LBU   = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SB    = 4'b1001;
    localparam logic [OPC_W-1:0] OP_LW    = 4'b1010;
    localparam logic [OPC_W-1:0] OP_SW    = 4'b1011;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'b1100;
    localparam logic [OPC_W-1:0] OP_ATYPE = 4'b1111;

    localparam logic [FNC_W-1:0] FN_ADD = 4'b0000;
    localparam logic [FNC_W-1:0] FN_SUB = 4'b0001;
    localparam logic [FNC_W-1:0] FN_MUL = 4'b0100;
    localparam logic [FNC_W-1:0] FN_DIV = 4'b0101;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_MUL = 3'b100;
    localparam logic [ALU_W-1:0] ALU_DIV = 3'b101;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_LT = 2'b01;
    localparam logic [1:0] BR_GT = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef struct packed {
        logic             alu_src_a;
        logic             alu_src_b;
        logic [ALU_W-1:0] alu_op;
        logic             brnch;
        logic             jmp;
        logic [1:0]       brnch_op;
        logic             illegal;
        logic             mem_r;
        logic             mem_w;
        logic             byte_en;
        logic             reg_w;
        logic             r15_w;
        logic [1:0]       wb_src;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

    function automatic logic is_mc(input ctrl_t c);
        return (c.alu_op == ALU_MUL) || (c.alu_op == ALU_DIV);
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational opcode/funct to control-bundle decoder (ctrl_decode).
// MUL/DIV funct codes decode as legal only when MULTICYCLE_EN is defined.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int FN_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    output ctrl_t           ctrl
);

    logic [ALU_W-1:0] a_op;
    logic             a_ok;

    always_comb begin
        a_op = ALU_ADD;
        a_ok = 1'b1;
        case (funct)
            FN_ADD:  a_op = ALU_ADD;
            FN_SUB:  a_op = ALU_SUB;
`ifdef MULTICYCLE_EN
            FN_MUL:  a_op = ALU_MUL;
            FN_DIV:  a_op = ALU_DIV;
`endif
            default: a_ok = 1'b0;
        endcase
    end

    always_comb begin
        ctrl = CTRL_ZERO;
        unique case (1'b1)
            (opcode == OP_ATYPE): begin
                if (a_ok) begin
                    ctrl.alu_op = a_op;
                    ctrl.reg_w  = 1'b1;
                    ctrl.wb_src = WB_ALU;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            (opcode == OP_LBU): begin
                ctrl.mem_r     = 1'b1;
                ctrl.byte_en   = 1'b1;
                ctrl.reg_w     = 1'b1;
                ctrl.wb_src    = WB_MEM;
                ctrl.alu_src_b = 1'b1;
            end
            (opcode == OP_SB): begin
                ctrl.mem_w     = 1'b1;
                ctrl.byte_en   = 1'b1;
                ctrl.alu_src_b = 1'b1;
            end
            (opcode == OP_LW): begin
                ctrl.mem_r     = 1'b1;
                ctrl.reg_w     = 1'b1;
                ctrl.wb_src    = WB_MEM;
                ctrl.alu_src_b = 1'b1;
            end
            (opcode == OP_SW): begin
                ctrl.mem_w     = 1'b1;
                ctrl.alu_src_b = 1'b1;
            end
            (opcode == OP_ADDI): begin
                ctrl.reg_w     = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            (opcode == OP_BLT): begin
                ctrl.brnch    = 1'b1;
                ctrl.brnch_op = BR_LT;
                ctrl.alu_op   = ALU_SUB;
            end
            (opcode == OP_BGT): begin
                ctrl.brnch    = 1'b1;
                ctrl.brnch_op = BR_GT;
                ctrl.alu_op   = ALU_SUB;
            end
            (opcode == OP_BEQ): begin
                ctrl.brnch    = 1'b1;
                ctrl.brnch_op = BR_EQ;
                ctrl.alu_op   = ALU_SUB;
            end
            (opcode == OP_JMP): begin
                ctrl.jmp    = 1'b1;
                ctrl.r15_w  = 1'b1;
                ctrl.wb_src = WB_PC;
            end
            (opcode == OP_NOP): begin
                ctrl = CTRL_ZERO;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX..MEM/WB control registers,
// flush/stall bubbles and the MULTICYCLE_EN-guarded MUL/DIV sequencer.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int FN_W    = 4,
    parameter int ALUOP_W = 3,
    parameter int MC_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FN_W-1:0]    funct,
    input  logic               hazard_stall,
    input  logic               brnch_taken,
    output logic               ex_aluSrcA,
    output logic               ex_aluSrcB,
    output logic [ALUOP_W-1:0] ex_aluOP,
    output logic               ex_brnch,
    output logic               ex_jmp,
    output logic [1:0]         ex_brnchOP,
    output logic               ex_illegal,
    output logic               mem_memR,
    output logic               mem_memW,
    output logic               mem_byteEN,
    output logic               wb_regW,
    output logic               wb_R15w,
    output logic [1:0]         wb_WBsrc,
    output logic               pc_stall,
    output logic               IF_IDclr,
    output logic               mc_busy
);

    if (MC_LAT < 2) begin : g_lat_chk
        $error("MC_LAT must be at least 2");
    end

    ctrl_t id_ctrl;
    ctrl_t id_ex;
    ctrl_t ex_mem;
    ctrl_t mem_wb;
    logic  flush;
    logic  busy;
    logic  mc_last;
    logic  mc_drain;

    ctrl_decode #(
        .OP_W (OP_W),
        .FN_W (FN_W)
    ) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .ctrl   (id_ctrl)
    );

    assign flush = (id_ex.brnch & brnch_taken) | id_ex.jmp;

`ifdef MULTICYCLE_EN
    localparam int CW = $clog2(MC_LAT);

    typedef enum logic {IDLE, BUSY} mc_state_t;

    mc_state_t     state;
    mc_state_t     state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          drain_q;
    logic          drain_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            drain_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            drain_q <= drain_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        drain_nx = 1'b0;
        mc_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush && !hazard_stall && is_mc(id_ctrl)) begin
                    state_nx = BUSY;
                    cnt_nx   = CW'(MC_LAT - 1);
                end
            end
            BUSY: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = IDLE;
                    mc_last  = 1'b1;
                    drain_nx = 1'b1;
                end
            end
        endcase
    end

    assign busy     = (state == BUSY);
    // MUL/DIV already went to MEM on the last busy edge; its final EX
    // cycle must not send a second copy.
    assign mc_drain = drain_q;
`else
    assign busy     = 1'b0;
    assign mc_last  = 1'b0;
    assign mc_drain = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex  <= CTRL_ZERO;
            ex_mem <= CTRL_ZERO;
            mem_wb <= CTRL_ZERO;
        end else begin
            mem_wb <= ex_mem;
            if (flush)
                id_ex <= CTRL_ZERO;
            else if (busy)
                id_ex <= id_ex;
            else if (hazard_stall)
                id_ex <= CTRL_ZERO;
            else
                id_ex <= id_ctrl;
            if (busy && !mc_last)
                ex_mem <= CTRL_ZERO;
            else if (mc_drain)
                ex_mem <= CTRL_ZERO;
            else
                ex_mem <= id_ex;
        end
    end

    assign pc_stall = rst_n & (busy | (hazard_stall & ~flush));
    assign IF_IDclr = flush;
    assign mc_busy  = busy;

    assign ex_aluSrcA = id_ex.alu_src_a;
    assign ex_aluSrcB = id_ex.alu_src_b;
    assign ex_aluOP   = id_ex.alu_op;
    assign ex_brnch   = id_ex.brnch;
    assign ex_jmp     = id_ex.jmp;
    assign ex_brnchOP = id_ex.brnch_op;
    assign ex_illegal = id_ex.illegal;

    assign mem_memR   = ex_mem.mem_r;
    assign mem_memW   = ex_mem.mem_w;
    assign mem_byteEN = ex_mem.byte_en;

    assign wb_regW  = mem_wb.reg_w;
    assign wb_R15w  = mem_wb.r15_w;
    assign wb_WBsrc = mem_wb.wb_src;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit; expected stage contents are
// queued per driven cycle and compared mid-cycle.
module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = '0;
    logic [3:0] funct = '0;
    logic       hazard_stall = 1'b0;
    logic       brnch_taken = 1'b0;
    logic       ex_aluSrcA, ex_aluSrcB, ex_brnch, ex_jmp, ex_illegal;
    logic [2:0] ex_aluOP;
    logic [1:0] ex_brnchOP, wb_WBsrc;
    logic       mem_memR, mem_memW, mem_byteEN;
    logic       wb_regW, wb_R15w, pc_stall, IF_IDclr, mc_busy;

    pipe_ctrl_unit #(
        .OP_W(4), .FN_W(4), .ALUOP_W(3), .MC_LAT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .opcode(opcode), .funct(funct),
        .hazard_stall(hazard_stall), .brnch_taken(brnch_taken),
        .ex_aluSrcA(ex_aluSrcA), .ex_aluSrcB(ex_aluSrcB),
        .ex_aluOP(ex_aluOP), .ex_brnch(ex_brnch), .ex_jmp(ex_jmp),
        .ex_brnchOP(ex_brnchOP), .ex_illegal(ex_illegal),
        .mem_memR(mem_memR), .mem_memW(mem_memW),
        .mem_byteEN(mem_byteEN),
        .wb_regW(wb_regW), .wb_R15w(wb_R15w), .wb_WBsrc(wb_WBsrc),
        .pc_stall(pc_stall), .IF_IDclr(IF_IDclr), .mc_busy(mc_busy)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] I_NOP = 8'h00, I_JMP = 8'h10, I_ILL = 8'h30;
    localparam logic [7:0] I_BLT = 8'h50, I_BEQ = 8'h60, I_LBU = 8'h80;
    localparam logic [7:0] I_SB = 8'h90, I_LW = 8'hA0, I_SW = 8'hB0;
    localparam logic [7:0] I_ADDI = 8'hC0, I_ADD = 8'hF0, I_SUB = 8'hF1;
    localparam logic [7:0] I_MUL = 8'hF4, I_DIV = 8'hF5;

    typedef struct packed {
        int         id;
        ctrl_t      ex;
        ctrl_t      mem;
        ctrl_t      wb;
        logic [2:0] ctl;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_id = 0;

    ctrl_t Z, c_lw, c_beq, c_blt, c_add, c_sub, c_mul, c_div;
    ctrl_t c_sw, c_ill, c_jmp, c_addi, c_lbu, c_sb;

    function automatic ctrl_t rd(input logic [7:0] ins);
        ctrl_t c;
        c = '0;
        case (ins[7:4])
            4'b1111: begin
                c.reg_w = 1'b1;
                case (ins[3:0])
                    4'b0000: c.alu_op = 3'b000;
                    4'b0001: c.alu_op = 3'b001;
`ifdef MULTICYCLE_EN
                    4'b0100: c.alu_op = 3'b100;
                    4'b0101: c.alu_op = 3'b101;
`endif
                    default: begin
                        c.reg_w = 1'b0;
                        c.illegal = 1'b1;
                    end
                endcase
            end
            4'b1000: begin
                c.mem_r = 1; c.byte_en = 1; c.reg_w = 1;
                c.wb_src = 2'b01; c.alu_src_b = 1;
            end
            4'b1001: begin
                c.mem_w = 1; c.byte_en = 1; c.alu_src_b = 1;
            end
            4'b1010: begin
                c.mem_r = 1; c.reg_w = 1;
                c.wb_src = 2'b01; c.alu_src_b = 1;
            end
            4'b1011: begin c.mem_w = 1; c.alu_src_b = 1; end
            4'b1100: begin c.reg_w = 1; c.alu_src_b = 1; end
            4'b0101: begin
                c.brnch = 1; c.brnch_op = 2'b01; c.alu_op = 3'b001;
            end
            4'b0100: begin
                c.brnch = 1; c.brnch_op = 2'b10; c.alu_op = 3'b001;
            end
            4'b0110: begin
                c.brnch = 1; c.brnch_op = 2'b00; c.alu_op = 3'b001;
            end
            4'b0001: begin
                c.jmp = 1; c.r15_w = 1; c.wb_src = 2'b10;
            end
            4'b0000: c = '0;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic [9:0] exv(input ctrl_t c);
        return {c.alu_src_a, c.alu_src_b, c.alu_op, c.brnch,
                c.jmp, c.brnch_op, c.illegal};
    endfunction

    function automatic logic [2:0] memv(input ctrl_t c);
        return {c.mem_r, c.mem_w, c.byte_en};
    endfunction

    function automatic logic [3:0] wbv(input ctrl_t c);
        return {c.reg_w, c.r15_w, c.wb_src};
    endfunction

    wire [9:0] o_ex = {ex_aluSrcA, ex_aluSrcB, ex_aluOP, ex_brnch,
                       ex_jmp, ex_brnchOP, ex_illegal};
    wire [2:0] o_mem = {mem_memR, mem_memW, mem_byteEN};
    wire [3:0] o_wb  = {wb_regW, wb_R15w, wb_WBsrc};
    wire [2:0] o_ctl = {pc_stall, IF_IDclr, mc_busy};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ex"}, 32'(o_ex), 32'd0);
        chk({tag, "_mem"}, 32'(o_mem), 32'd0);
        chk({tag, "_wb"}, 32'(o_wb), 32'd0);
        chk({tag, "_ctl"}, 32'(o_ctl), 32'd0);
    endtask

    task automatic push(input ctrl_t x, input ctrl_t m,
                        input ctrl_t w, input logic [2:0] ctl);
        exp_t t;
        t.id = n_id;
        t.ex = x;
        t.mem = m;
        t.wb = w;
        t.ctl = ctl;
        n_id++;
        sb.push_back(t);
    endtask

    task automatic cyc(input logic [7:0] ins, input logic hz,
                       input logic bt, input ctrl_t x, input ctrl_t m,
                       input ctrl_t w, input logic [2:0] ctl);
        opcode = ins[7:4];
        funct = ins[3:0];
        hazard_stall = hz;
        brnch_taken = bt;
        push(x, m, w, ctl);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("ex#%0d", e.id), 32'(o_ex), 32'(exv(e.ex)));
            chk($sformatf("mem#%0d", e.id), 32'(o_mem), 32'(memv(e.mem)));
            chk($sformatf("wb#%0d", e.id), 32'(o_wb), 32'(wbv(e.wb)));
            chk($sformatf("ctl#%0d", e.id), 32'(o_ctl), 32'(e.ctl));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Z = '0;
        c_lw = rd(I_LW);    c_beq = rd(I_BEQ);  c_blt = rd(I_BLT);
        c_add = rd(I_ADD);  c_sub = rd(I_SUB);  c_mul = rd(I_MUL);
        c_div = rd(I_DIV);  c_sw = rd(I_SW);    c_ill = rd(I_ILL);
        c_jmp = rd(I_JMP);  c_addi = rd(I_ADDI); c_lbu = rd(I_LBU);
        c_sb = rd(I_SB);

        hazard_stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        hazard_stall = 1'b0;
        rst_n = 1'b1;

        cyc(I_LW,   0, 0, Z,      Z,      Z,      3'b000);
        cyc(I_NOP,  0, 0, c_lw,   Z,      Z,      3'b000);
        cyc(I_NOP,  0, 0, Z,      c_lw,   Z,      3'b000);
        cyc(I_NOP,  0, 0, Z,      Z,      c_lw,   3'b000);
        cyc(I_BEQ,  0, 0, Z,      Z,      Z,      3'b000);
        cyc(I_ADD,  0, 1, c_beq,  Z,      Z,      3'b010);
        cyc(I_NOP,  0, 1, Z,      c_beq,  Z,      3'b000);
        cyc(I_NOP,  0, 0, Z,      Z,      c_beq,  3'b000);
        cyc(I_BLT,  0, 0, Z,      Z,      Z,      3'b000);
        cyc(I_ADD,  0, 0, c_blt,  Z,      Z,      3'b000);
        cyc(I_NOP,  0, 0, c_add,  c_blt,  Z,      3'b000);
        cyc(I_NOP,  0, 0, Z,      c_add,  c_blt,  3'b000);
        cyc(I_JMP,  0, 0, Z,      Z,      c_add,  3'b000);
        cyc(I_ADD,  0, 0, c_jmp,  Z,      Z,      3'b010);
        cyc(I_NOP,  0, 0, Z,      c_jmp,  Z,      3'b000);
        cyc(I_NOP,  0, 0, Z,      Z,      c_jmp,  3'b000);
        cyc(I_SW,   1, 0, Z,      Z,      Z,      3'b100);
        cyc(I_SW,   0, 0, Z,      Z,      Z,      3'b000);
        cyc(I_NOP,  0, 0, c_sw,   Z,      Z,      3'b000);
        cyc(I_NOP,  0, 0, Z,      c_sw,   Z,      3'b000);
        cyc(I_ILL,  0, 0, Z,      Z,      c_sw,   3'b000);
        cyc(I_NOP,  0, 0, c_ill,  Z,      Z,      3'b000);
        cyc(I_ADDI, 0, 0, Z,      c_ill,  Z,      3'b000);
        cyc(I_LBU,  0, 0, c_addi, Z,      c_ill,  3'b000);
        cyc(I_SB,   0, 0, c_lbu,  c_addi, Z,      3'b000);
        cyc(I_SUB,  0, 0, c_sb,   c_lbu,  c_addi, 3'b000);
        cyc(I_NOP,  0, 0, c_sub,  c_sb,   c_lbu,  3'b000);
        cyc(I_NOP,  0, 0, Z,      c_sub,  c_sb,   3'b000);
        cyc(I_NOP,  0, 0, Z,      Z,      c_sub,  3'b000);

`ifdef MULTICYCLE_EN
        cyc(I_MUL,  0, 0, Z,      Z,      Z,      3'b000);
        cyc(I_ADD,  0, 0, c_mul,  Z,      Z,      3'b101);
        cyc(I_ADD,  0, 0, c_mul,  Z,      Z,      3'b101);
        cyc(I_ADD,  0, 0, c_mul,  Z,      Z,      3'b101);
        cyc(I_ADD,  0, 0, c_mul,  c_mul,  Z,      3'b000);
        cyc(I_NOP,  0, 0, c_add,  Z,      c_mul,  3'b000);
        cyc(I_NOP,  0, 0, Z,      c_add,  Z,      3'b000);
        cyc(I_DIV,  0, 0, Z,      Z,      c_add,  3'b000);
        cyc(I_NOP,  0, 0, c_div,  Z,      Z,      3'b101);
        cyc(I_NOP,  0, 0, c_div,  Z,      Z,      3'b101);
        cyc(I_NOP,  0, 0, c_div,  Z,      Z,      3'b101);
        cyc(I_NOP,  0, 0, c_div,  c_div,  Z,      3'b000);
        cyc(I_NOP,  0, 0, Z,      Z,      c_div,  3'b000);
        cyc(I_MUL,  0, 0, Z,      Z,      Z,      3'b000);
        cyc(I_NOP,  0, 0, c_mul,  Z,      Z,      3'b101);
        opcode = 4'h0;
        funct = 4'h0;
        push(c_mul, Z, Z, 3'b101);
`else
        cyc(I_MUL,  0, 0, Z,      Z,      Z,      3'b000);
        cyc(I_ADD,  0, 0, c_mul,  Z,      Z,      3'b000);
        cyc(I_NOP,  0, 0, c_add,  c_mul,  Z,      3'b000);
        cyc(I_DIV,  0, 0, Z,      c_add,  c_mul,  3'b000);
        cyc(I_NOP,  0, 0, c_div,  Z,      c_add,  3'b000);
        cyc(I_MUL,  0, 0, Z,      c_div,  Z,      3'b000);
        cyc(I_NOP,  0, 0, c_mul,  Z,      c_div,  3'b000);
        opcode = 4'h0;
        funct = 4'h0;
        push(Z, c_mul, Z, 3'b000);
`endif
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        @(posedge clk);
        #1;
        chk_zero("hold");
        rst_n = 1'b1;
        repeat (4) cyc(I_NOP, 0, 0, Z, Z, Z, 3'b000);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Pipelined successor to the combinational control decoder. It decodes opcode/funct in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB stage registers. It inserts bubbles for load-use stalls and taken branches/jumps, and sequences multi-cycle MUL/DIV in EX with a busy counter. It sits beside the datapath stage registers in the 5-stage pipeline.

Parameters:
OP_W, 4, opcode width
FN_W, 4, funct width (A-type only)
ALUOP_W, 3, ALU operation code width
MC_LAT, 4, EX occupancy in cycles for MUL/DIV (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OP_W  ID-stage opcode
funct  in  FN_W  ID-stage function code
hazard_stall  in  1  load-use stall request from hazard unit
brnch_taken  in  1  EX branch condition true
ex_aluSrcA, ex_aluSrcB  out  1  EX operand selects
ex_aluOP  out  ALUOP_W  EX ALU op
ex_brnch, ex_jmp  out  1  EX branch/jump flags
ex_brnchOP  out  2  00 BEQ, 01 BLT, 10 BGT
ex_illegal  out  1  EX holds undecodable instruction
mem_memR, mem_memW, mem_byteEN  out  1  MEM controls
wb_regW, wb_R15w  out  1  WB write enables
wb_WBsrc  out  2  00 ALU, 01 MEM, 10 R15/PC+2
pc_stall  out  1  hold PC and IF/ID
IF_IDclr  out  1  flush IF/ID
mc_busy  out  1  multi-cycle op occupying EX

Behaviour:
- Decode map, funct used only for opcode 1111:
  - 1111: funct 0000 ADD, 0001 SUB, 0100 MUL, 0101 DIV; regW=1, WBsrc=00
  - 1000 LBU: memR, byteEN, regW, WBsrc=01, aluSrcB=1
  - 1001 SB: memW, byteEN, aluSrcB=1
  - 1010 LW: memR, regW, WBsrc=01, aluSrcB=1
  - 1011 SW: memW, aluSrcB=1
  - 1100 ADDI: regW, aluSrcB=1
  - 0101 BLT, 0100 BGT, 0110 BEQ: brnch, brnchOP as listed
  - 0001 JMP: jmp, R15w, WBsrc=10
  - 0000 NOP: all zero
  - anything else: zero bundle with illegal=1
- aluOP: ADD 000, SUB 001, MUL 100, DIV 101, ADDI 000, branches 001.
- Reset (async, rst_n=0): every stage register is cleared to the zero bundle; all outputs 0; FSM IDLE; counter 0. Reset mid-MUL abandons the op.
- Latency: an instruction in ID at cycle n appears on ex_* at n+1, mem_* at n+2 and wb_* at n+3, absent stalls.
- Flush: (ex_brnch & brnch_taken) | ex_jmp sets IF_IDclr=1 combinationally in the same cycle, and ID/EX loads the zero bundle on the next edge. brnch_taken is ignored when ex_brnch=0.
- Multi-cycle FSM:
  - IDLE -> BUSY when ID/EX loads MUL/DIV; counter loads MC_LAT-1.
  - In BUSY: mc_busy=1, pc_stall=1, ID/EX holds, EX/MEM loads the zero bundle, counter decrements.
  - When counter=1 and BUSY, next edge returns to IDLE and EX/MEM captures the MUL/DIV bundle.
  - Net effect: the op occupies EX for exactly MC_LAT cycles.
- Load-use: hazard_stall=1 in IDLE gives pc_stall=1 and ID/EX loads the zero bundle. The ID instruction is retried the next cycle.
- Priority: rst_n > flush > mc BUSY hold > hazard_stall > normal advance. The flush condition cannot co-occur with BUSY, since EX holds MUL/DIV.
- EX/MEM -> MEM/WB always advances.
- Outputs are driven directly from stage registers, except IF_IDclr and pc_stall, which are combinational.

Optional Feature:
MULTICYCLE_EN
- Defined: MUL/DIV decode as above; FSM and counter are present.
- Undefined: opcodes 1111/0100 and 1111/0101 decode as illegal with single-cycle flow; mc_busy is tied 0; no FSM or counter logic is built.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode/funct localparams;
  - aluOP and brnchOP encodings;
  - WBsrc encodings;
  - ctrl bundle struct-like field widths and the zero-bundle constant.
- One sub-module, ctrl_decode: purely combinational opcode/funct -> bundle + illegal, reused by later variants.
- FSM and stage registers stay in pipe_ctrl_unit.

Test Plan:
- Reset release, then LW (1010) for 1 cycle followed by NOP -> cycle+1 ex_aluSrcB=1; cycle+2 mem_memR=1; cycle+3 wb_regW=1, wb_WBsrc=01.
- BEQ in EX with brnch_taken=1 -> IF_IDclr=1 that cycle; next cycle ex_* all 0, even though ADD (1111/0000) was in ID.
- MUL (1111/0100), MC_LAT=4, ADD behind it -> mc_busy=1 for 3 cycles, pc_stall=1, mem_* zero for 3 cycles, then ex_aluOP=000 (ADD) enters EX.
- hazard_stall=1 for 1 cycle with SW in ID -> pc_stall=1, one bubble in EX, SW appears on ex_* one cycle late.
- opcode 0011 -> ex_illegal=1 one cycle later and all other controls 0. Without MULTICYCLE_EN, 1111/0101 also gives ex_illegal=1 and mc_busy stays 0.
- rst_n low during mc BUSY (counter=2) -> all outputs 0 immediately, mc_busy=0; after release, a NOP stream keeps everything at 0.
